// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Sequences one decoded load / store / cache-op from the EX stage onto the
//   data-side SRAM-style bus (req / addr_ok / data_ok). It returns an aligned,
//   sign- or zero-extended load result to the pipeline. At most one
//   transaction is in flight. While busy, the controller holds off EX through
//   mem_ready.
//
// Optional feature:
//   MEM_CACOP_EN - when defined, CACOP issues a bus request with
//                  data_cacop=1. When undefined, CACOP retires as a
//                  one-cycle nop and data_cacop is tied low.
//
// Ports:
//   clk, reset        core clock; synchronous active-high reset
//   ex_valid          EX holds a valid instruction
//   ex_op[7:0]        decoded op code (OP_LD / OP_LDU / OP_ST / OP_CACOP)
//   ex_size[1:0]      00 byte, 01 half, 10 word, 11 treated as word
//   ex_addr[31:0]     effective address
//   ex_wdata[31:0]    store data
//   ex_flush          cancel the current or accepted op
//   mem_ready         controller can accept (EX allowin term)
//   mem_done          one-cycle completion pulse
//   mem_rdata[31:0]   extended load data (0 for ST / CACOP), held between dones
//   mem_ale           address misaligned, valid with mem_done
//   data_req/_wr      bus request / write
//   data_size[1:0]    0 byte, 1 half, 2 word
//   data_addr/_wdata  bus address / replicated write data
//   data_wstrb[3:0]   byte-lane write strobes
//   data_cacop        request is a cache op
//   data_addr_ok      bus accepted the request
//   data_data_ok      bus returned / committed data
//   data_rdata[31:0]  bus read data
// ============================================================================
module mem_access_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [7:0]  ex_op,
    input  logic [1:0]  ex_size,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic        ex_flush,
    output logic        mem_ready,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic        mem_ale,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    output logic        data_cacop,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    // Op encodings shared with the ID-stage decoder (defs.v).
    localparam logic [7:0] OP_LD    = 8'h01;
    localparam logic [7:0] OP_LDU   = 8'h02;
    localparam logic [7:0] OP_ST    = 8'h03;
    localparam logic [7:0] OP_CACOP = 8'h04;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Size code 11 is folded onto word.
    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        logic [1:0] r;
        r = (sz == 2'b11) ? SZ_WORD : sz;
        return r;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        logic r;
        case (sz)
            SZ_HALF: r = off[0];
            SZ_WORD: r = (off != 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] calc_wstrb(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] r;
        case (sz)
            SZ_BYTE: r = 4'b0001 << off;
            SZ_HALF: r = 4'b0011 << off;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    // Replicate narrow store data onto every lane, so the strobes alone
    // select which lane the memory commits.
    function automatic logic [31:0] calc_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        case (sz)
            SZ_BYTE: r = {4{wd[7:0]}};
            SZ_HALF: r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] rd,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  off,
                                                input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (sz)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic        discard_q, discard_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [1:0]  req_size_q, req_size_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [3:0]  req_wstrb_q, req_wstrb_d;
    logic        op_st_q, op_st_d;
    logic        op_load_q, op_load_d;
    logic        op_sign_q, op_sign_d;
`ifdef MEM_CACOP_EN
    logic        op_cacop_q, op_cacop_d;
`endif
    logic        mem_done_q, mem_done_d;
    logic        mem_ale_q, mem_ale_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    // ------------------------------------------------------------------
    // Accept decode
    // ------------------------------------------------------------------
    logic       is_ld, is_ldu, is_st, is_cacop, is_mem_op;
    logic       accept, acc_bus, accept_bus, accept_quick, acc_mis;
    logic [1:0] acc_size;
    logic       bus_done, deliver;

    always_comb begin
        is_ld     = (ex_op == OP_LD);
        is_ldu    = (ex_op == OP_LDU);
        is_st     = (ex_op == OP_ST);
        is_cacop  = (ex_op == OP_CACOP);
        is_mem_op = is_ld | is_ldu | is_st | is_cacop;

        accept    = ex_valid & mem_ready & ~ex_flush & is_mem_op;
        acc_size  = norm_size(ex_size);
        // Cache ops carry a line address, so they are never alignment-checked.
        acc_mis   = ~is_cacop & is_misaligned(acc_size, ex_addr[1:0]);
`ifdef MEM_CACOP_EN
        acc_bus   = ~acc_mis;
`else
        acc_bus   = ~acc_mis & ~is_cacop;
`endif
        accept_bus   = accept & acc_bus;
        // Misaligned ops (and CACOP when disabled) retire without touching the bus.
        accept_quick = accept & ~acc_bus;

        // data_ok only counts once the address phase has been accepted,
        // either in WAIT or together with addr_ok in REQ.
        bus_done = ((state_q == S_REQ) & data_addr_ok & data_data_ok) |
                   ((state_q == S_WAIT) & data_data_ok);
        // A flush seen earlier (discard) or in the completion cycle itself
        // swallows the result; the bus transaction has still finished.
        deliver  = bus_done & ~discard_q & ~ex_flush;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_bus) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // The request is never withdrawn, even on flush.
                if (data_addr_ok) begin
                    state_d = data_data_ok ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        // Gated by reset so every output reads 0 while reset is held.
        mem_ready  = (state_q == S_IDLE) & ~reset;
        data_req   = (state_q == S_REQ);
        data_wr    = data_req & op_st_q;
`ifdef MEM_CACOP_EN
        data_cacop = data_req & op_cacop_q;
`else
        data_cacop = 1'b0;
`endif
        data_addr  = req_addr_q;
        data_size  = req_size_q;
        data_wdata = req_wdata_q;
        data_wstrb = req_wstrb_q;
        mem_done   = mem_done_q;
        mem_ale    = mem_ale_q;
        mem_rdata  = mem_rdata_q;
    end

    // ------------------------------------------------------------------
    // Datapath next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        req_addr_d  = req_addr_q;
        req_size_d  = req_size_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        op_st_d     = op_st_q;
        op_load_d   = op_load_q;
        op_sign_d   = op_sign_q;
`ifdef MEM_CACOP_EN
        op_cacop_d  = op_cacop_q;
`endif
        mem_rdata_d = mem_rdata_q;
        discard_d   = discard_q;

        // Latch the request on accept; it stays stable through the REQ stall.
        if (accept_bus) begin
            req_addr_d  = ex_addr;
            req_size_d  = acc_size;
            req_wdata_d = calc_wdata(acc_size, ex_wdata);
            req_wstrb_d = is_st ? calc_wstrb(acc_size, ex_addr[1:0]) : 4'b0000;
            op_st_d     = is_st;
            op_load_d   = is_ld | is_ldu;
            op_sign_d   = is_ld;
`ifdef MEM_CACOP_EN
            op_cacop_d  = is_cacop;
            if (is_cacop) begin
                req_size_d  = SZ_WORD;
                req_wdata_d = 32'h0;
            end
`endif
        end

        mem_done_d = accept_quick | deliver;
        mem_ale_d  = accept_quick & acc_mis;

        if (accept_quick) begin
            mem_rdata_d = 32'h0;
        end else if (deliver) begin
            mem_rdata_d = op_load_q ? extend_load(data_rdata, req_size_q,
                                                  req_addr_q[1:0], op_sign_q)
                                    : 32'h0;
        end

        if ((state_q == S_IDLE) || bus_done) begin
            discard_d = 1'b0;
        end else if (ex_flush) begin
            discard_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            discard_q   <= 1'b0;
            req_addr_q  <= 32'h0;
            req_size_q  <= 2'b00;
            req_wdata_q <= 32'h0;
            req_wstrb_q <= 4'b0000;
            op_st_q     <= 1'b0;
            op_load_q   <= 1'b0;
            op_sign_q   <= 1'b0;
`ifdef MEM_CACOP_EN
            op_cacop_q  <= 1'b0;
`endif
            mem_done_q  <= 1'b0;
            mem_ale_q   <= 1'b0;
            mem_rdata_q <= 32'h0;
        end else begin
            discard_q   <= discard_d;
            req_addr_q  <= req_addr_d;
            req_size_q  <= req_size_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            op_st_q     <= op_st_d;
            op_load_q   <= op_load_d;
            op_sign_q   <= op_sign_d;
`ifdef MEM_CACOP_EN
            op_cacop_q  <= op_cacop_d;
`endif
            mem_done_q  <= mem_done_d;
            mem_ale_q   <= mem_ale_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

endmodule
